pipeline_stage_skid: RTL
========================

// Module: pipeline_stage_skid
// PURPOSE
//  Generalised inter-stage pipeline register for the RV32E pipeline.
//  Carries the destination register index, the result word and the register-file write enable between stages.
//  Adds a valid/ready handshake, a one-entry skid slot so in_ready is a registered signal, flush, and squash of writes.
//  Drop-in successor for the per-stage registers such as MEMPREP->MEMEX.
// PARAMETERS
//  DATA_W  32  width of the result payload (alu_result)
//  RD_W    4   width of the destination register index (4 for RV32E)
//  CNT_W   16  width of the performance counters (PIPE_PERF_CNT_EN only)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-high
//  flush       in   1       synchronous pipeline flush
//  in_valid    in   1       upstream word present
//  in_ready    out  1       stage can accept this cycle (registered)
//  in_invalid  in   1       upstream word is squashed: it flows through, but its write is suppressed
//  in_rd       in   RD_W    destination register index
//  in_data     in   DATA_W  result payload
//  in_we       in   1       register-file write enable
//  out_valid   out  1       output word present
//  out_ready   in   1       downstream accepts this cycle
//  out_rd      out  RD_W    held destination index
//  out_data    out  DATA_W  held payload
//  out_we      out  1       write enable; already ANDed with ~invalid at capture
//  stall_cnt   out  CNT_W   PIPE_PERF_CNT_EN only
//  bubble_cnt  out  CNT_W   PIPE_PERF_CNT_EN only
// BEHAVIOUR
//  - State: main slot {mv, rd, data, we} drives out_*; skid slot {sv, rd, data, we}. out_valid = mv; in_ready = ~sv.
//  - Reset (async, rst high): mv=0, sv=0, out_rd=0, out_data=0, out_we=0; in_ready=1.
//    No transfer occurs while rst=1. Reset mid-transfer drops both slots.
//  - Accept = in_valid & in_ready; Consume = out_valid & out_ready (both at posedge).
//  - Captured we = in_we & ~in_invalid. rd and data are captured unchanged.
//  - Transitions, when flush=0:
//    - main empty, accept          -> main <= in (latency 1 cycle)
//    - main full, consume, accept  -> main <= in (throughput 1 word/cycle)
//    - main full, consume, no acc. -> mv <= 0
//    - main full, no consume, acc. -> skid <= in, sv <= 1 (in_ready drops next cycle)
//    - skid full, consume          -> main <= skid, sv <= 0 (in_ready=0 this cycle, so no accept)
//  - Ordering is strictly FIFO: a skid word is never overtaken.
//  - flush=1: mv <= 0, sv <= 0 next edge.
//    Flush has priority over a simultaneous accept, which is discarded; an upstream handshake still counts as completed.
//    Payload regs may hold stale values; out_we is forced to 0 while mv=0.
//  - out_rd/out_data hold their last value while mv=0; consumers must qualify with out_valid.
//  - No combinational path from out_ready to in_ready.
// CONFIGURATION
//  - PIPE_PERF_CNT_EN defined:
//    - stall_cnt increments each cycle out_valid & ~out_ready.
//    - bubble_cnt increments each cycle out_ready & ~out_valid.
//    - Both saturate at all-ones, clear only on rst (not flush), and hold while rst=1.
//  - PIPE_PERF_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.
// TESTING
//  1. Reset: assert rst mid-cycle -> out_valid=0, out_we=0, out_rd=0, out_data=0, in_ready=1 immediately.
//  2. Streaming: out_ready=1; send rd=5/data=0x1234/we=1, then rd=6/0xBEEF/we=1 on consecutive cycles
//     -> each word appears one cycle later, back-to-back, in order.
//  3. Squash: in_invalid=1, in_we=1, rd=3, data=0xAAAA_5555 -> out_valid=1, out_rd=3, out_data=0xAAAA_5555, out_we=0.
//  4. Backpressure: out_ready=0, send words A,B -> A held on out, B in skid, in_ready=0.
//     Raise out_ready -> A then B consumed, in_ready=1 again. No loss, no duplicate.
//  5. Flush with a full skid while in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming word discarded.
//  6. Counters (PIPE_PERF_CNT_EN, CNT_W=4): 20 cycles with out_valid=1, out_ready=0
//     -> stall_cnt=15 (saturated); bubble_cnt unchanged.

Source files
------------

// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid
//   Inter-stage pipeline register for the RV32E pipeline carrying {rd, result, we}
//   with a valid/ready handshake. A one-entry skid slot behind the main slot lets
//   in_ready come straight from a flop, so out_ready never reaches in_ready
//   combinationally. Supports a synchronous flush and squashing of the
//   register-file write for words marked invalid upstream.
//
//   Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall/bubble counters.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               drop both slots at the next edge (wins over an accept)
//   in_valid/in_ready   upstream handshake; in_ready is registered (= ~skid valid)
//   in_invalid          squash: word flows through but its write enable is cleared
//   in_rd/in_data/in_we upstream payload
//   out_valid/out_ready downstream handshake
//   out_rd/out_data     main-slot payload, held while out_valid=0
//   out_we              main-slot write enable, forced low while out_valid=0
//   stall_cnt           cycles with out_valid & ~out_ready (PIPE_PERF_CNT_EN)
//   bubble_cnt          cycles with out_ready & ~out_valid (PIPE_PERF_CNT_EN)
module pipeline_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 4
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_invalid,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    // Skid slot
    logic              s_valid;
    logic [RD_W-1:0]   s_rd;
    logic [DATA_W-1:0] s_data;
    logic              s_we;

    // Next-state values
    logic              m_valid_d;
    logic [RD_W-1:0]   m_rd_d;
    logic [DATA_W-1:0] m_data_d;
    logic              m_we_d;
    logic              s_valid_d;
    logic [RD_W-1:0]   s_rd_d;
    logic [DATA_W-1:0] s_data_d;
    logic              s_we_d;

    logic accept_c;
    logic consume_c;
    logic cap_we_c;

    assign accept_c  = in_valid & in_ready;
    assign consume_c = out_valid & out_ready;
    assign cap_we_c  = in_we & ~in_invalid;

    // Next-state for main and skid slots
    always_comb begin
        m_valid_d = out_valid;
        m_rd_d    = out_rd;
        m_data_d  = out_data;
        m_we_d    = out_we;
        s_valid_d = s_valid;
        s_rd_d    = s_rd;
        s_data_d  = s_data;
        s_we_d    = s_we;

        if (flush) begin
            // Accepted word this cycle is discarded along with both slots
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid) begin
            // in_ready is low here, so no accept can collide with the refill
            if (consume_c) begin
                m_valid_d = 1'b1;
                m_rd_d    = s_rd;
                m_data_d  = s_data;
                m_we_d    = s_we;
                s_valid_d = 1'b0;
            end
        end else if (!out_valid || consume_c) begin
            // Main slot free (or freeing): take the new word directly
            m_valid_d = accept_c;
            if (accept_c) begin
                m_rd_d   = in_rd;
                m_data_d = in_data;
                m_we_d   = cap_we_c;
            end
        end else if (accept_c) begin
            // Main slot stalled: park the word in the skid slot
            s_valid_d = 1'b1;
            s_rd_d    = in_rd;
            s_data_d  = in_data;
            s_we_d    = cap_we_c;
        end

        // An empty main slot never advertises a write
        if (!m_valid_d) begin
            m_we_d = 1'b0;
        end
    end

    // Slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            out_we    <= 1'b0;
            s_valid   <= 1'b0;
            s_rd      <= '0;
            s_data    <= '0;
            s_we      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= m_valid_d;
            out_rd    <= m_rd_d;
            out_data  <= m_data_d;
            out_we    <= m_we_d;
            s_valid   <= s_valid_d;
            s_rd      <= s_rd_d;
            s_data    <= s_data_d;
            s_we      <= s_we_d;
            in_ready  <= ~s_valid_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating performance counters; cleared by rst only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (out_ready && !out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
